// File: rtl/axi_eth_ifm_rx_fsm.sv
// axi_eth_ifm_rx_fsm
//   RX frame mover: MAC RX AXI-stream -> inbound data FIFO + per-frame status
//   word into the inbound ctrl FIFO (s2mm clock domain).
//   Optional feature macro: IFM_RX_CSUM_EN builds the raw ones-complement
//   checksum datapath; without it the csum field of the status word is 0.
module axi_eth_ifm_rx_fsm #(
    parameter int CSUM_START = 14,
    parameter int MAX_BEATS  = 1190
) (
    input  logic        s2mm_clk,
    input  logic        s2mm_resetn,
    input  logic [63:0] rx_axis_mac_tdata,
    input  logic [7:0]  rx_axis_mac_tkeep,
    input  logic        rx_axis_mac_tlast,
    input  logic        rx_axis_mac_tuser,
    input  logic        rx_axis_mac_tvalid,
    input  logic        data_fifo_afull,
    input  logic        ctrl_fifo_afull,
    output logic [72:0] data_fifo_wdata,
    output logic        data_fifo_wren,
    output logic [33:0] ctrl_fifo_wdata,
    output logic        ctrl_fifo_wren,
    output logic [3:0]  ifm_in_fsm_dbg
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FRAME = 2'd1;
    localparam logic [1:0] S_TRUNC = 2'd2;
    localparam logic [1:0] S_DROP  = 2'd3;
    localparam int BW = $clog2(MAX_BEATS + 1);

    logic [1:0]    state_q, state_d;
    logic [BW-1:0] beats_q;
    logic [15:0]   len_q;
    logic [15:0]   csum_acc, csum_new;
    logic          accept, st_evt, hit_max, sof;
    logic [BW-1:0] idx;
    logic [3:0]    pop;
    logic [16:0]   len_sum;
    logic [15:0]   len_new;
    logic [33:0]   st_word;

    // beat acceptance, length accumulation, next state and status word
    always_comb begin
        sof     = (state_q == S_IDLE);
        accept  = rx_axis_mac_tvalid &&
                  ((sof && !(data_fifo_afull || ctrl_fifo_afull)) || state_q == S_FRAME);
        idx     = sof ? '0 : beats_q;
        hit_max = (idx == BW'(MAX_BEATS - 1));
        pop     = '0;
        for (int b = 0; b < 8; b++) pop = pop + 4'(rx_axis_mac_tkeep[b]);
        len_sum = 17'(sof ? 16'h0 : len_q) + 17'(pop);
        len_new = len_sum[16] ? 16'hFFFF : len_sum[15:0];
        // status fires on the MAC tlast of a written frame, or of a truncated one
        st_evt  = rx_axis_mac_tvalid && rx_axis_mac_tlast && (accept || state_q == S_TRUNC);
        st_word = accept ? {~rx_axis_mac_tuser, hit_max, len_new, csum_new}
                         : {~rx_axis_mac_tuser, 1'b1, len_q, csum_acc};
        state_d = state_q;
        if (rx_axis_mac_tvalid) begin
            if (accept)
                state_d = rx_axis_mac_tlast ? S_IDLE : (hit_max ? S_TRUNC : S_FRAME);
            else if (rx_axis_mac_tlast)
                state_d = S_IDLE;
            else if (sof)
                state_d = S_DROP;
        end
    end

`ifdef IFM_RX_CSUM_EN
    logic [15:0] csum_q;
    logic [7:0]  mb [8];
    logic [31:0] off;
    logic [18:0] csum_s;
    logic [16:0] csum_t;

    // mask bytes before CSUM_START or disabled by tkeep, add big-endian lanes,
    // fold end-around carry every beat so the held value is always 16 bits
    always_comb begin
        off = '0;
        for (int b = 0; b < 8; b++) begin
            off   = 32'(idx) * 32'd8 + 32'(b);
            mb[b] = (rx_axis_mac_tkeep[b] && off >= 32'(CSUM_START)) ?
                    rx_axis_mac_tdata[8*b +: 8] : 8'h00;
        end
        csum_s   = 19'(sof ? 16'h0 : csum_q) + 19'({mb[0], mb[1]}) + 19'({mb[2], mb[3]})
                 + 19'({mb[4], mb[5]}) + 19'({mb[6], mb[7]});
        csum_t   = 17'(csum_s[15:0]) + 17'(csum_s[18:16]);
        csum_new = csum_t[15:0] + 16'(csum_t[16]);
        csum_acc = csum_q;
    end

    // checksum accumulator advances only on written beats
    always_ff @(posedge s2mm_clk or negedge s2mm_resetn) begin
        if (!s2mm_resetn)  csum_q <= '0;
        else if (accept)   csum_q <= csum_new;
    end
`else
    assign csum_new = 16'h0000;
    assign csum_acc = 16'h0000;
`endif

    logic        dwren_q, st_vld_q, cwren_q;
    logic [72:0] dwdata_q;
    logic [33:0] st_word_q, cwdata_q;

    // FSM, frame counters and the 1-cycle data write register
    always_ff @(posedge s2mm_clk or negedge s2mm_resetn) begin
        if (!s2mm_resetn) begin
            state_q  <= S_IDLE;
            beats_q  <= '0;
            len_q    <= '0;
            dwren_q  <= 1'b0;
            dwdata_q <= '0;
        end else begin
            state_q <= state_d;
            dwren_q <= accept;
            if (accept) begin
                beats_q  <= idx + 1'b1;
                len_q    <= len_new;
                dwdata_q <= {rx_axis_mac_tlast | hit_max, rx_axis_mac_tkeep, rx_axis_mac_tdata};
            end
        end
    end

    // two-stage status pipeline: capture at tlast, present one cycle later
    always_ff @(posedge s2mm_clk or negedge s2mm_resetn) begin
        if (!s2mm_resetn) begin
            st_vld_q  <= 1'b0;
            st_word_q <= '0;
            cwren_q   <= 1'b0;
            cwdata_q  <= '0;
        end else begin
            st_vld_q <= st_evt;
            if (st_evt) st_word_q <= st_word;
            cwren_q <= st_vld_q;
            if (st_vld_q) cwdata_q <= st_word_q;
        end
    end

    assign data_fifo_wren  = dwren_q;
    assign data_fifo_wdata = dwdata_q;
    assign ctrl_fifo_wren  = cwren_q;
    assign ctrl_fifo_wdata = cwdata_q;
    assign ifm_in_fsm_dbg  = {2'b00, state_q};
endmodule

// File: tb/tb_axi_eth_ifm_rx_fsm.sv
// Scoreboard bench: two instances (default MAX_BEATS and MAX_BEATS=4) share
// the stimulus; a frame-level model pushes expected writes, monitors pop them.
module tb_axi_eth_ifm_rx_fsm;
    localparam int MAXA = 1190;
    localparam int MAXB = 4;
    localparam int CSS  = 14;

    logic        clk = 0, rst_n = 0;
    logic [63:0] tdata = '0;
    logic [7:0]  tkeep = '0;
    logic        tlast = 0, tuser = 0, tvalid = 0, dafull = 0, cafull = 0;
    logic [72:0] dwd_a, dwd_b;
    logic [33:0] cwd_a, cwd_b;
    logic        dwr_a, dwr_b, cwr_a, cwr_b;
    logic [3:0]  dbg_a, dbg_b;

    always #5 clk = ~clk;

    axi_eth_ifm_rx_fsm u_a (
        .s2mm_clk(clk), .s2mm_resetn(rst_n),
        .rx_axis_mac_tdata(tdata), .rx_axis_mac_tkeep(tkeep), .rx_axis_mac_tlast(tlast),
        .rx_axis_mac_tuser(tuser), .rx_axis_mac_tvalid(tvalid),
        .data_fifo_afull(dafull), .ctrl_fifo_afull(cafull),
        .data_fifo_wdata(dwd_a), .data_fifo_wren(dwr_a),
        .ctrl_fifo_wdata(cwd_a), .ctrl_fifo_wren(cwr_a), .ifm_in_fsm_dbg(dbg_a));

    axi_eth_ifm_rx_fsm #(.MAX_BEATS(MAXB)) u_b (
        .s2mm_clk(clk), .s2mm_resetn(rst_n),
        .rx_axis_mac_tdata(tdata), .rx_axis_mac_tkeep(tkeep), .rx_axis_mac_tlast(tlast),
        .rx_axis_mac_tuser(tuser), .rx_axis_mac_tvalid(tvalid),
        .data_fifo_afull(dafull), .ctrl_fifo_afull(cafull),
        .data_fifo_wdata(dwd_b), .data_fifo_wren(dwr_b),
        .ctrl_fifo_wdata(cwd_b), .ctrl_fifo_wren(cwr_b), .ifm_in_fsm_dbg(dbg_b));

    typedef struct { logic [72:0] d; int cyc; } exp_d_t;
    typedef struct { logic [33:0] d; int cyc; } exp_s_t;
    exp_d_t qda[$], qdb[$];
    exp_s_t qsa[$], qsb[$];
    logic [63:0] fd[$];
    int n_chk = 0, n_fail = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // monitor: pop and compare whenever a write strobe is presented
    always @(negedge clk) begin
        exp_d_t ed;
        exp_s_t es;
        if (dwr_a) begin
            if (qda.size() == 0) chk("A data unexpected write", 1, 0);
            else begin ed = qda.pop_front(); chk("A data word", dwd_a, ed.d); chk("A data cycle", cyc, ed.cyc); end
        end
        if (dwr_b) begin
            if (qdb.size() == 0) chk("B data unexpected write", 1, 0);
            else begin ed = qdb.pop_front(); chk("B data word", dwd_b, ed.d); chk("B data cycle", cyc, ed.cyc); end
        end
        if (cwr_a) begin
            if (qsa.size() == 0) chk("A status unexpected write", 1, 0);
            else begin es = qsa.pop_front(); chk("A status word", cwd_a, es.d); chk("A status cycle", cyc, es.cyc); end
        end
        if (cwr_b) begin
            if (qsb.size() == 0) chk("B status unexpected write", 1, 0);
            else begin es = qsb.pop_front(); chk("B status word", cwd_b, es.d); chk("B status cycle", cyc, es.cyc); end
        end
    end

    // frame-level reference: bytes actually written, summed with plain arithmetic
    function automatic logic [33:0] exp_status(input int n, input logic [7:0] lk, input logic tu, input int maxb);
        int w = (n < maxb) ? n : maxb;
        longint len = 0, sum = 0;
        logic [15:0] cs;
        logic [7:0] k;
        logic [63:0] d;
        for (int i = 0; i < w; i++) begin
            k = (i == n - 1) ? lk : 8'hFF;
            d = fd[i];
            len += $countones(k);
            for (int b = 0; b < 8; b++)
                if (k[b] && (i * 8 + b) >= CSS)
                    sum += (b % 2 == 0) ? longint'(d[8*b +: 8]) * 256 : longint'(d[8*b +: 8]);
        end
        if (len > 65535) len = 65535;
`ifdef IFM_RX_CSUM_EN
        cs = (sum == 0) ? 16'h0 : 16'(((sum - 1) % 65535) + 1);
`else
        cs = 16'h0;
`endif
        return {~tu, (n >= maxb), 16'(len), cs};
    endfunction

    function automatic logic [3:0] exp_dbg(input int i, input int af, input int maxb);
        if (i == 0) return 4'd0;
        if (af != 0) return 4'd3;
        return (i < maxb) ? 4'd1 : 4'd2;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            tvalid = 0; tlast = 0;
            dafull = 1'($urandom); cafull = 1'($urandom);
        end
    endtask

    // drive the frame in fd; af: 0 none, 1 data afull, 2 ctrl afull at SOF
    task automatic send_frame(input logic [7:0] lk, input logic tu, input int af, input int gmax);
        int n = fd.size();
        exp_d_t ed;
        exp_s_t es;
        for (int i = 0; i < n; i++) begin
            if (i > 0) idle($urandom_range(0, gmax));
            @(posedge clk); #1;
            chk("A dbg state", dbg_a, exp_dbg(i, af, MAXA));
            chk("B dbg state", dbg_b, exp_dbg(i, af, MAXB));
            tvalid = 1;
            tdata  = fd[i];
            tlast  = (i == n - 1);
            tkeep  = (i == n - 1) ? lk : 8'hFF;
            tuser  = (i == n - 1) ? tu : 1'($urandom);
            dafull = (i == 0) ? (af == 1) : 1'($urandom);
            cafull = (i == 0) ? (af == 2) : 1'($urandom);
            if (af == 0) begin
                ed.cyc = cyc + 1;
                if (i < MAXA) begin ed.d = {(i == n - 1) || (i == MAXA - 1), tkeep, tdata}; qda.push_back(ed); end
                if (i < MAXB) begin ed.d = {(i == n - 1) || (i == MAXB - 1), tkeep, tdata}; qdb.push_back(ed); end
                if (i == n - 1) begin
                    es.cyc = cyc + 2;
                    es.d = exp_status(n, lk, tu, MAXA); qsa.push_back(es);
                    es.d = exp_status(n, lk, tu, MAXB); qsb.push_back(es);
                end
            end
        end
    endtask

    task automatic fill_rand(input int n);
        fd.delete();
        for (int i = 0; i < n; i++) fd.push_back({$urandom, $urandom});
    endtask

    task automatic fill_t1();
        fd.delete();
        for (int i = 0; i < 8; i++) fd.push_back(64'h0);
        fd[1] = 64'h3412_0000_0000_0000;
    endtask

    initial begin
        exp_d_t ed;
        logic [63:0] saved[$];
        #2;
        chk("reset A outputs", {dwr_a, cwr_a, dwd_a, cwd_a, dbg_a}, '0);
        chk("reset B outputs", {dwr_b, cwr_b, dwd_b, cwd_b, dbg_b}, '0);
        @(posedge clk); #1; rst_n = 1;
        idle(2);

        // 64B good frame with 0x1234 at bytes 14/15
        fill_t1();      send_frame(8'hFF, 1, 0, 0); idle(3);
        // 61B bad frame
        fill_rand(8);   send_frame(8'h1F, 0, 0, 0); idle(3);
        // afull at SOF drops the whole frame, next one is accepted
        fill_rand(8);   send_frame(8'hFF, 1, 1, 1); idle(1);
        fill_rand(8);   send_frame(8'hFF, 1, 2, 0);
        fill_rand(8);   send_frame(8'hFF, 1, 0, 0); idle(3);
        // 6-beat frame: truncated by the MAX_BEATS=4 instance
        fill_rand(6);   send_frame(8'hFF, 1, 0, 1); idle(3);
        // back-to-back 1-beat frames
        for (int f = 0; f < 4; f++) begin fill_rand(1); send_frame(8'hFF, 1, 0, 0); end
        idle(4);

        // reset on beat 3 of an 8-beat frame
        fill_rand(8);
        saved = fd;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            tvalid = 1; tdata = fd[i]; tkeep = 8'hFF; tlast = 0; tuser = 0;
            dafull = 0; cafull = 0;
            ed.cyc = cyc + 1; ed.d = {1'b0, 8'hFF, fd[i]};
            qda.push_back(ed); qdb.push_back(ed);
        end
        @(posedge clk); #1;
        tdata = fd[2];
        #6 rst_n = 0;
        #1;
        chk("mid-frame reset A outputs", {dwr_a, cwr_a, dwd_a, cwd_a, dbg_a}, '0);
        chk("mid-frame reset B outputs", {dwr_b, cwr_b, dwd_b, cwd_b, dbg_b}, '0);
        @(posedge clk); #1;
        tvalid = 0;
        chk("held reset A outputs", {dwr_a, cwr_a, dbg_a}, '0);
        @(posedge clk); #1; rst_n = 1;
        // remaining beats form a fresh frame after reset release
        fd.delete();
        for (int i = 3; i < 8; i++) fd.push_back(saved[i]);
        send_frame(8'hFF, 1, 0, 0); idle(2);
        fill_t1();      send_frame(8'hFF, 1, 0, 0); idle(3);

        // randomized frames
        for (int f = 0; f < 80; f++) begin
            fill_rand($urandom_range(1, 12));
            send_frame(8'hFF >> $urandom_range(0, 7), 1'($urandom),
                       ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0, 2);
            idle($urandom_range(0, 2));
        end
        idle(6);

        chk("A data queue drained",   qda.size(), 0);
        chk("B data queue drained",   qdb.size(), 0);
        chk("A status queue drained", qsa.size(), 0);
        chk("B status queue drained", qsb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
